// File: rtl/mem_port_arbiter_if.sv
// Bundles the IFU, LSU and memory-side signals of the shared memory port.
// The arbiter takes the slave view (it serves both requesters and drives the
// memory request); the surrounding core/memory model takes the master view.
interface mem_port_arbiter_if;
  // instruction fetch side
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic [63:0] ifu_rdata;
  logic        ifu_done;
  // load/store side
  logic        lsu_req;
  logic        lsu_wen;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic [63:0] lsu_rdata;
  logic        lsu_done;
  // memory side
  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_rdata, ifu_done,
    input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_rdata, lsu_done,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport master (
    output ifu_req, ifu_addr,
    input  ifu_rdata, ifu_done,
    output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_rdata, lsu_done,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU. LSU has priority, but after
// LSU_STREAK consecutive LSU grants with a fetch waiting, the IFU is forced
// through. Each access is a req/ack transaction guarded by a timeout; every
// transaction ends with a one-cycle done pulse to its owner.
module mem_port_arbiter #(
  parameter int LSU_STREAK = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst,          // asynchronous, active-low
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          owner,
  output logic                timeout_err
);

  localparam int STREAK_W = $clog2(LSU_STREAK + 1);
  localparam int TMO_W    = $clog2(TIMEOUT);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wen_q, mem_wen_d;
  logic [63:0]         mem_addr_q, mem_addr_d;
  logic [63:0]         mem_wdata_q, mem_wdata_d;
  logic [7:0]          mem_wmask_q, mem_wmask_d;
  logic                ifu_done_q, ifu_done_d;
  logic                lsu_done_q, lsu_done_d;
  logic [63:0]         ifu_rdata_q, ifu_rdata_d;
  logic [63:0]         lsu_rdata_q, lsu_rdata_d;
  logic [1:0]          owner_q, owner_d;
  logic                timeout_err_q, timeout_err_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

  logic streak_full;
  assign streak_full = (streak_q == STREAK_W'(LSU_STREAK));

  // Next-state: arbitration in IDLE, ack/timeout in BUSY, single-cycle DONE.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_wen_d     = mem_wen_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    ifu_done_d    = 1'b0;
    lsu_done_d    = 1'b0;
    ifu_rdata_d   = ifu_rdata_q;
    lsu_rdata_d   = lsu_rdata_q;
    owner_d       = owner_q;
    timeout_err_d = timeout_err_q;
    streak_d      = streak_q;
    tmo_cnt_d     = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.lsu_req && !(bus.ifu_req && streak_full)) begin
          // LSU wins unless a waiting fetch has been passed over too often
          state_d     = S_BUSY;
          owner_d     = OWN_LSU;
          mem_req_d   = 1'b1;
          mem_wen_d   = bus.lsu_wen;
          mem_addr_d  = bus.lsu_addr;
          mem_wdata_d = bus.lsu_wdata;
          mem_wmask_d = bus.lsu_wen ? bus.lsu_wmask : 8'h00;
          if (bus.ifu_req && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (bus.ifu_req) begin
          state_d     = S_BUSY;
          owner_d     = OWN_IFU;
          mem_req_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_addr_d  = bus.ifu_addr;
          mem_wdata_d = 64'h0;
          mem_wmask_d = 8'h00;
          streak_d    = '0;
        end else begin
          owner_d = OWN_NONE;
        end
      end

      S_BUSY: begin
        if (bus.mem_ack && mem_req_q) begin
          state_d    = S_DONE;
          mem_req_d  = 1'b0;
          ifu_done_d = (owner_q == OWN_IFU);
          lsu_done_d = (owner_q == OWN_LSU);
          if (owner_q == OWN_IFU) ifu_rdata_d = bus.mem_rdata;
          if (owner_q == OWN_LSU) lsu_rdata_d = bus.mem_rdata;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          // abort: complete the transaction with zero data and flag it
          state_d       = S_DONE;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          ifu_done_d    = (owner_q == OWN_IFU);
          lsu_done_d    = (owner_q == OWN_LSU);
          if (owner_q == OWN_IFU) ifu_rdata_d = 64'h0;
          if (owner_q == OWN_LSU) lsu_rdata_d = 64'h0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_DONE: begin
        // done pulse is visible this cycle; no arbitration until IDLE
        tmo_cnt_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      mem_addr_q    <= 64'h0;
      mem_wdata_q   <= 64'h0;
      mem_wmask_q   <= 8'h00;
      ifu_done_q    <= 1'b0;
      lsu_done_q    <= 1'b0;
      ifu_rdata_q   <= 64'h0;
      lsu_rdata_q   <= 64'h0;
      owner_q       <= OWN_NONE;
      timeout_err_q <= 1'b0;
      streak_q      <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_wen_q     <= mem_wen_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
      ifu_done_q    <= ifu_done_d;
      lsu_done_q    <= lsu_done_d;
      ifu_rdata_q   <= ifu_rdata_d;
      lsu_rdata_q   <= lsu_rdata_d;
      owner_q       <= owner_d;
      timeout_err_q <= timeout_err_d;
      streak_q      <= streak_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.ifu_done  = ifu_done_q;
  assign bus.lsu_done  = lsu_done_q;
  assign bus.ifu_rdata = ifu_rdata_q;
  assign bus.lsu_rdata = lsu_rdata_q;
  assign owner         = owner_q;
  assign timeout_err   = timeout_err_q;

endmodule
